// File: rtl/ysyx_22040365_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040365_wb_arbiter
// Purpose  : Writeback arbiter (EXU/LSU -> single RF write port) with a
//            destination-register busy scoreboard for hazard and WAW stalls.
//            Define YSYX_22040365_WB_RR_EN for round-robin arbitration;
//            otherwise LSU has fixed priority over EXU.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040365_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [AW-1:0]   exu_rd,
    input  logic [XLEN-1:0] exu_data,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,

    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rd,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            hazard,

    input  logic            flush,

    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int c_NREG = 1 << AW;

    logic              w_grant_exu;
    logic              w_grant_lsu;
    logic              w_block;
    logic              w_exu_fire;
    logic              w_lsu_fire;
    logic              w_fire;
    logic [AW-1:0]     w_sel_rd;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_iss_fire;
    logic [c_NREG-1:0] r_busy;
    logic [c_NREG-1:0] w_busy_next;

`ifdef YSYX_22040365_WB_RR_EN
    // 0 = EXU won the last transfer, 1 = LSU; reset to 1 so EXU goes first.
    logic r_last_grant;

    always_comb begin
        w_grant_lsu = lsu_valid && (!exu_valid || !r_last_grant);
        w_grant_exu = exu_valid && !w_grant_lsu;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_fire) begin
            r_last_grant <= w_lsu_fire;
        end
    end
`else
    always_comb begin
        w_grant_lsu = lsu_valid;
        w_grant_exu = exu_valid && !lsu_valid;
    end
`endif

    // Reset and flush both close every handshake in the current cycle.
    assign w_block    = rst || flush;
    assign exu_ready  = w_grant_exu && !w_block;
    assign lsu_ready  = w_grant_lsu && !w_block;
    assign w_exu_fire = exu_valid && exu_ready;
    assign w_lsu_fire = lsu_valid && lsu_ready;
    assign w_fire     = w_exu_fire || w_lsu_fire;
    assign w_sel_rd   = w_lsu_fire ? lsu_rd   : exu_rd;
    assign w_sel_data = w_lsu_fire ? lsu_data : exu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // x0 writes complete the handshake but never reach the RF.
            rf_wen <= w_fire && (w_sel_rd != '0);
            if (w_fire && (w_sel_rd != '0)) begin
                rf_waddr <= w_sel_rd;
                rf_wdata <= w_sel_data;
            end
        end
    end

    assign iss_ready  = !r_busy[iss_rd] && !w_block;
    assign w_iss_fire = iss_valid && iss_ready;
    assign hazard     = r_busy[rs1_addr] | r_busy[rs2_addr];

    // Set is applied after clear so a same-register collision stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (rf_wen) begin
            w_busy_next[rf_waddr] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040365_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040365_wb_arbiter
// Purpose  : Directed self-checking bench with a write-port scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040365_wb_arbiter;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            exu_valid, lsu_valid, iss_valid, flush;
    logic            exu_ready, lsu_ready, iss_ready, hazard;
    logic [AW-1:0]   exu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0] exu_data, lsu_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            exp_lsu;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_err    = 0;

    always #5 clk = ~clk;

    ysyx_22040365_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .hazard    (hazard),
        .flush     (flush),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Advance one cycle, then compare the registered write port to the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rf_wen", rf_wen, 1);
            chk("rf_waddr", rf_waddr, e.addr);
            chk("rf_wdata", rf_wdata, e.data);
        end else begin
            chk("rf_wen_idle", rf_wen, 0);
        end
    endtask

    task automatic idle();
        exu_valid = 0;
        lsu_valid = 0;
        iss_valid = 0;
        flush     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; idle();
        exu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        exu_data = 0; lsu_data = 0;

        // Reset: readies held low, outputs cleared, issue ignored
        tick();
        exu_valid = 1; lsu_valid = 1; iss_valid = 1; iss_rd = 3;
        #3;
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        tick();
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        rst = 0; idle(); rs1_addr = 3; rs2_addr = 31;
        #3;
        chk("rst_hazard", hazard, 0);

        // Arbitration with both requesters valid for four cycles
        for (int k = 0; k < 4; k++) begin
            tick();
            exu_valid = 1; exu_rd = 1; exu_data = 64'h1000 + 64'(k);
            lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h2000 + 64'(k);
            #3;
`ifdef YSYX_22040365_WB_RR_EN
            exp_lsu = (k % 2) == 1;
`else
            exp_lsu = 1'b1;
`endif
            chk("arb_exu_ready", exu_ready, {63'd0, !exp_lsu});
            chk("arb_lsu_ready", lsu_ready, {63'd0, exp_lsu});
            if (exp_lsu) push_wr(2, 64'h2000 + 64'(k));
            else         push_wr(1, 64'h1000 + 64'(k));
        end

        // Single EXU transfer, latency 1, one-cycle rf_wen pulse
        tick();
        lsu_valid = 0; exu_valid = 1; exu_rd = 5; exu_data = 64'h1234;
        #3;
        chk("exu_ready_single", exu_ready, 1);
        push_wr(5, 64'h1234);
        tick();
        exu_valid = 0;
        tick();

        // Issue rd=7, hazard and WAW stall until the write retires
        iss_valid = 1; iss_rd = 7;
        #3;
        chk("iss7_ready", iss_ready, 1);
        tick();
        rs1_addr = 7; rs2_addr = 0;
        #3;
        chk("hazard7_set", hazard, 1);
        chk("iss7_waw_stall", iss_ready, 0);
        tick();
        exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
        #3;
        chk("iss7_still_stalled", iss_ready, 0);
        chk("exu7_ready", exu_ready, 1);
        push_wr(7, 64'h77);
        tick();
        exu_valid = 0;
        #3;
        chk("hazard7_no_bypass", hazard, 1);
        chk("iss7_stall_commit", iss_ready, 0);
        tick();
        #3;
        chk("hazard7_cleared", hazard, 0);
        chk("iss7_ready_again", iss_ready, 1);
        tick();
        iss_valid = 0;
        #3;
        chk("hazard7_reissued", hazard, 1);

        // x0 writeback and x0 issue
        tick();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hdead;
        iss_valid = 1; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        #3;
        chk("lsu_x0_ready", lsu_ready, 1);
        chk("iss_x0_ready", iss_ready, 1);
        chk("hazard_x0", hazard, 0);
        tick();
        lsu_valid = 0; iss_valid = 0;
        #3;
        chk("hazard_x0_after", hazard, 0);
        rs1_addr = 7;
        #1;
        chk("busy7_unchanged", hazard, 1);

        // Set/clear collision, then flush
        rs1_addr = 0;
        tick();
        iss_valid = 1; iss_rd = 3;
        #3;
        chk("iss3_ready", iss_ready, 1);
        tick();
        iss_rd = 9; exu_valid = 1; exu_rd = 8; exu_data = 64'h88;
        #3;
        chk("iss9_ready", iss_ready, 1);
        chk("exu8_ready", exu_ready, 1);
        push_wr(8, 64'h88);
        tick();
        exu_valid = 0; iss_rd = 8;
        #3;
        chk("iss8_ready", iss_ready, 1);
        tick();
        iss_valid = 0; rs1_addr = 8; rs2_addr = 0;
        #3;
        chk("set_wins_busy8", hazard, 1);
        rs1_addr = 3; rs2_addr = 9;
        #1;
        chk("hazard_3_9", hazard, 1);
        flush = 1;
        exu_valid = 1; exu_rd = 10; exu_data = 64'haa;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 64'hbb;
        iss_valid = 1; iss_rd = 12;
        #2;
        chk("flush_exu_ready", exu_ready, 0);
        chk("flush_lsu_ready", lsu_ready, 0);
        chk("flush_iss_ready", iss_ready, 0);
        tick();
        idle();
        #3;
        chk("flush_hazard_3_9", hazard, 0);
        rs1_addr = 8; rs2_addr = 7;
        #1;
        chk("flush_hazard_8_7", hazard, 0);

        // Reset the cycle after an accepted write to rd=4
        tick();
        iss_valid = 1; iss_rd = 4;
        #3;
        chk("iss4_ready", iss_ready, 1);
        tick();
        iss_rd = 6;
        #3;
        chk("iss6_ready", iss_ready, 1);
        tick();
        iss_valid = 0; exu_valid = 1; exu_rd = 4; exu_data = 64'h4444;
        #3;
        chk("exu4_ready", exu_ready, 1);
        push_wr(4, 64'h4444);
        tick();
        rst = 1;
        exu_rd = 11; exu_data = 64'h1111; lsu_valid = 1; lsu_rd = 13;
        iss_valid = 1; iss_rd = 13;
        #3;
        chk("rst2_exu_ready", exu_ready, 0);
        chk("rst2_lsu_ready", lsu_ready, 0);
        chk("rst2_iss_ready", iss_ready, 0);
        tick();
        rst = 0; idle();
        chk("rst2_rf_waddr", rf_waddr, 0);
        chk("rst2_rf_wdata", rf_wdata, 0);
        rs1_addr = 4; rs2_addr = 6;
        #3;
        chk("rst2_hazard_4_6", hazard, 0);

        // Normal operation resumes after reset
        tick();
        lsu_valid = 1; lsu_rd = 12; lsu_data = 64'hc0ffee;
        #3;
        chk("post_rst_lsu_ready", lsu_ready, 1);
        push_wr(12, 64'hc0ffee);
        tick();
        lsu_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22040365_wb_arbiter.md
YSYX_22040365_WB_ARBITER -- requirements
Module: ysyx_22040365_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning writeback data width.
REQ-002 SHALL have parameter AW, default 5, meaning register address width (32 architectural registers).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports exu_valid in 1, exu_ready out 1, exu_rd in AW, exu_data in XLEN: ALU writeback request channel.
REQ-006 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_rd in AW, lsu_data in XLEN: load writeback request channel.
REQ-007 SHALL have ports iss_valid in 1, iss_ready out 1, iss_rd in AW: issue-stage claim of a destination register.
REQ-008 SHALL have ports rs1_addr in AW, rs2_addr in AW, hazard out 1: source-operand busy query.
REQ-009 SHALL have port flush in 1: pipeline flush.
REQ-010 SHALL have ports rf_wen out 1, rf_waddr out AW, rf_wdata out XLEN: the single register-file write port, all registered.

Function
REQ-011 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high in the same cycle.
REQ-012 SHALL drive exu_ready/lsu_ready combinationally from grant; ready of a non-valid requester is don't-care but SHALL NOT cause a transfer.
REQ-013 SHALL register an accepted transfer into rf_wen/rf_waddr/rf_wdata one cycle later (latency 1); rf_wen SHALL be high for exactly one cycle per transfer.
REQ-014 SHALL accept transfers with rd = 0 (handshake completes) but SHALL hold rf_wen low for them.
REQ-015 SHALL keep a 32-bit busy scoreboard; busy[0] is constant 0.
REQ-016 SHALL set busy[iss_rd] on an issue handshake (iss_valid and iss_ready) when iss_rd != 0.
REQ-017 SHALL clear busy[rf_waddr] in the cycle rf_wen is high.
REQ-018 SHALL apply set and clear of different registers in the same cycle independently; set SHALL win when both target the same register.
REQ-019 SHALL drive iss_ready = !busy[iss_rd] && !flush (WAW stall); iss_rd = 0 is always ready unless flush.
REQ-020 SHALL drive hazard = busy[rs1_addr] | busy[rs2_addr], combinational from the current scoreboard (no same-cycle bypass of a committing write).
REQ-021 SHALL, while flush is high, drive exu_ready, lsu_ready and iss_ready low; the next cycle SHALL have all busy bits 0 and rf_wen 0.
REQ-022 SHALL keep the arbitration pointer last_grant (0 = EXU, 1 = LSU), updated only on a completed transfer.

Reset
REQ-023 SHALL, while rst is high at a clock edge, clear busy to all zeros, rf_wen to 0, rf_waddr to 0, rf_wdata to 0, last_grant to 1 (EXU favoured first).
REQ-024 SHALL take rst priority over flush, issue and writeback in the same cycle; a request in flight is dropped with no rf_wen.
REQ-025 SHALL hold all ready outputs low while rst is high.

Configuration
REQ-026 SHALL use macro YSYX_22040365_WB_RR_EN to select the arbitration policy.
REQ-027 SHALL, with YSYX_22040365_WB_RR_EN defined, grant round-robin: when both valid, grant the requester that is not last_grant.
REQ-028 SHALL, without YSYX_22040365_WB_RR_EN, grant fixed priority LSU over EXU; last_grant is then unused.
REQ-029 SHALL, in both modes, grant the only valid requester when exactly one is valid.

Verification
REQ-030 SHALL cover: reset, then exu_valid=1, exu_rd=5, exu_data=0x1234 -> exu_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_wen=0.
REQ-031 SHALL cover: both valid for 4 cycles (exu_rd=1, lsu_rd=2) -> RR build grants EXU,LSU,EXU,LSU; fixed build grants LSU all 4 cycles.
REQ-032 SHALL cover: issue iss_rd=7, then rs1_addr=7 -> hazard=1 and a second iss_rd=7 sees iss_ready=0 until the cycle after rf_wen with rf_waddr=7, then hazard=0.
REQ-033 SHALL cover: lsu transfer with lsu_rd=0 -> lsu_ready=1, rf_wen stays 0; issue iss_rd=0 -> busy unchanged, hazard for rs1_addr=0 stays 0.
REQ-034 SHALL cover: busy[3] and busy[9] set, flush=1 one cycle with exu_valid=1 -> exu_ready=0, next cycle hazard=0 for rs1=3, rs2=9 and rf_wen=0.
REQ-035 SHALL cover: rst asserted the cycle after an accepted write to rd=4 -> rf_wen=0, busy[4]=0 after reset.
